amm_ahb_arbiter: RTL and testbench
==================================

# amm_ahb_arbiter

Round-robin arbiter that shares one AHB-Lite master port between up to four Avalon-MM requesters. Each requester sees a standard waitrequest/readdatavalid slave. The block serialises their single transfers onto AHB with registered address/control outputs. It sits between the CPU/DMA Avalon masters and the AHB peripheral fabric, and replaces per-master bridges when masters share one bus.

## Interface
- N_PORTS, 2, number of Avalon requesters (legal 2..4)
- aclk  in  1  clock, both sides
- aresetn  in  1  async active-low reset, aclk domain
- amm_address  in  32*N_PORTS  per-port byte address, port p at [32p+31:32p]
- amm_writedata  in  32*N_PORTS  per-port write data
- amm_byteenable  in  4*N_PORTS  per-port byte enables
- amm_write / amm_read  in  N_PORTS  per-port command strobes
- amm_waitrequest  out  N_PORTS  low for exactly one cycle when that port's command completes
- amm_readdata  out  32  shared read data, qualified by amm_readdatavalid
- amm_readdatavalid  out  N_PORTS  one-cycle pulse per completed read
- amm_response  out  N_PORTS  1 = AHB error on the completed transfer, valid in the ack cycle
- ahb_haddr  out  32; ahb_hsize  out  3; ahb_htrans  out  2; ahb_hwrite  out  1; ahb_hwdata  out  32; ahb_hburst  out  3 (constant SINGLE 3'b000)
- ahb_hrdata  in  32; ahb_hresp  in  1; ahb_hready  in  1

## Operation
- FSM states: IDLE, ADDR, DATA, DONE. One outstanding transfer; no pipelining between grants.
- IDLE: req[p] = amm_read[p] | amm_write[p].
  - Grant goes to the first requesting port after last_grant, in modulo-N_PORTS order.
  - The block latches the granted port's address, size, write flag and writedata into output registers, sets ahb_htrans=NONSEQ and moves to ADDR.
  - No request: stay in IDLE with htrans=IDLE.
- ADDR: hold NONSEQ and control until ahb_hready=1, then drop htrans to IDLE and go to DATA. ahb_hwdata is already valid here and stays stable through DATA.
- DATA: wait for ahb_hready=1.
  - Capture ahb_hrdata into amm_readdata (reads only).
  - Capture ahb_hresp into a response register.
  - Go to DONE.
- DONE: amm_waitrequest[g]=0 for this one cycle.
  - For a read, amm_readdatavalid[g]=1.
  - amm_response[g]=captured hresp.
  - last_grant<=g, then go to IDLE.
- Byteenable to hsize/haddr[1:0] mapping:
  - 0001/0010/0100/1000 -> BYTE with lsb 00/01/10/11.
  - 0011 -> HWORD, lsb 00; 1100 -> HWORD, lsb 10.
  - Any other pattern -> WORD, lsb 00.
- haddr[31:2] comes from amm_address.
- read and write asserted together on one port: illegal; the write takes precedence.
- A requester that drops its command before its ack is illegal. The block still completes the latched transfer and pulses the ack.
- Non-granted ports keep waitrequest=1.

## Timing
- Reset values:
  - htrans=00, haddr=0, hwrite=0, hsize=010, hwdata=0.
  - amm_waitrequest=all 1, amm_readdatavalid=0, amm_readdata=0, amm_response=0.
  - state=IDLE, last_grant=N_PORTS-1, so port 0 wins first.
- Zero-wait transfer: request seen at IDLE cycle 0 -> NONSEQ in cycle 1 -> data phase in cycle 2 -> waitrequest low (and readdatavalid) in cycle 3.
- Each hready-low cycle in ADDR or DATA adds one cycle.
- Back-to-back: DONE -> IDLE -> ADDR. Best case is 4 cycles per transfer.
- Fairness: with all ports continuously requesting, grants rotate 0,1,..,N-1. No port waits more than N_PORTS-1 transfers.
- A request asserted during DONE on the just-acked port is a new command. It competes at the following IDLE with lowest priority.
- Reset mid-transfer: all outputs return to reset values asynchronously. An abandoned transfer produces no ack. The AHB slave shares aresetn.
- hresp=1 while hready=0 (first error cycle) is ignored. Only hresp sampled with hready=1 in DATA is reported.

## Test plan
- Single word write, port 0, addr 0x100, data 0xDEADBEEF, hready=1 -> NONSEQ at cycle 1 with hsize=010 and hwrite=1, hwdata=0xDEADBEEF in cycle 2, waitrequest[0] low in cycle 3 only.
- Byte read, port 1, byteenable 0100, slave hrdata=0x00AB0000 with 2 wait states in DATA -> haddr[1:0]=10, hsize=000, readdatavalid[1] in cycle 5 with readdata=0x00AB0000.
- All ports (N=4) continuously requesting from reset -> grant order 0,1,2,3,0 and exactly one ack per 4 cycles.
- Slave error on a port 0 write (hresp=1 for two cycles, hready low then high) -> amm_response[0]=1 in the ack cycle, and 0 on the next transfer.
- aresetn asserted while in DATA of a read -> htrans=00 and waitrequest=all 1 immediately, no readdatavalid; after release, port 0 is granted first.
- Port 0 holds read and write together -> AHB write is issued, hwrite=1.

Source files
------------

// File: rtl/amm_ahb_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite master port between N_PORTS Avalon-MM
// requesters; one single transfer in flight at a time, registered AHB controls.
module amm_ahb_arbiter #(
    parameter int N_PORTS = 2
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [32*N_PORTS-1:0]  amm_address,
    input  logic [32*N_PORTS-1:0]  amm_writedata,
    input  logic [4*N_PORTS-1:0]   amm_byteenable,
    input  logic [N_PORTS-1:0]     amm_write,
    input  logic [N_PORTS-1:0]     amm_read,
    output logic [N_PORTS-1:0]     amm_waitrequest,
    output logic [31:0]            amm_readdata,
    output logic [N_PORTS-1:0]     amm_readdatavalid,
    output logic [N_PORTS-1:0]     amm_response,
    output logic [31:0]            ahb_haddr,
    output logic [2:0]             ahb_hsize,
    output logic [1:0]             ahb_htrans,
    output logic                   ahb_hwrite,
    output logic [31:0]            ahb_hwdata,
    output logic [2:0]             ahb_hburst,
    input  logic [31:0]            ahb_hrdata,
    input  logic                   ahb_hresp,
    input  logic                   ahb_hready
);
    localparam int GW = $clog2(N_PORTS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    state_t             state_q, state_d;
    logic [N_PORTS-1:0] req;
    xfer_t              xfer [N_PORTS];
    xfer_t              cur_q;
    logic [GW-1:0]      grant_q, last_grant_q, gnt_next;
    logic               gnt_found;
    logic [1:0]         htrans_q;
    logic               resp_q;
    logic [31:0]        rdata_q;

    // {hsize, haddr[1:0]} for a byteenable pattern; unusual patterns fall back to a word
    function automatic logic [4:0] be_map(input logic [3:0] be);
        case (be)
            4'b0001: be_map = {3'b000, 2'b00};
            4'b0010: be_map = {3'b000, 2'b01};
            4'b0100: be_map = {3'b000, 2'b10};
            4'b1000: be_map = {3'b000, 2'b11};
            4'b0011: be_map = {3'b001, 2'b00};
            4'b1100: be_map = {3'b001, 2'b10};
            default: be_map = {3'b010, 2'b00};
        endcase
    endfunction

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [4:0] sz_lsb;
        logic [1:0] addr_lsb_unused;
        logic       ack;

        assign sz_lsb          = be_map(amm_byteenable[4*p +: 4]);
        assign addr_lsb_unused = amm_address[32*p +: 2];
        assign req[p]          = amm_read[p] | amm_write[p];
        // write wins when both strobes are up
        assign xfer[p] = {amm_address[32*p+2 +: 30], sz_lsb[1:0], sz_lsb[4:2],
                          amm_write[p], amm_writedata[32*p +: 32]};

        assign ack                  = (state_q == DONE) && (grant_q == GW'(p));
        assign amm_waitrequest[p]   = ~ack;
        assign amm_readdatavalid[p] = ack & ~cur_q.write;
        assign amm_response[p]      = ack & resp_q;
    end

    // first requester after the last grant, wrapping modulo N_PORTS
    always_comb begin
        gnt_found = 1'b0;
        gnt_next  = last_grant_q;
        for (int i = 1; i <= N_PORTS; i++) begin
            if (!gnt_found && req[GW'((int'(last_grant_q) + i) % N_PORTS)]) begin
                gnt_found = 1'b1;
                gnt_next  = GW'((int'(last_grant_q) + i) % N_PORTS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found)  state_d = ADDR;
            ADDR:    if (ahb_hready) state_d = DATA;
            DATA:    if (ahb_hready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_PORTS - 1);
            cur_q        <= {32'h0, 3'b010, 1'b0, 32'h0};
            htrans_q     <= 2'b00;
            resp_q       <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (gnt_found) begin
                    grant_q  <= gnt_next;
                    cur_q    <= xfer[gnt_next];
                    htrans_q <= 2'b10;
                end
                ADDR: if (ahb_hready) htrans_q <= 2'b00;
                // hresp during a wait state is the first half of a two-cycle error; skip it
                DATA: if (ahb_hready) begin
                    resp_q <= ahb_hresp;
                    if (!cur_q.write) rdata_q <= ahb_hrdata;
                end
                DONE: last_grant_q <= grant_q;
                default: ;
            endcase
        end
    end

    assign ahb_htrans   = htrans_q;
    assign ahb_haddr    = cur_q.addr;
    assign ahb_hsize    = cur_q.size;
    assign ahb_hwrite   = cur_q.write;
    assign ahb_hwdata   = cur_q.wdata;
    assign ahb_hburst   = 3'b000;
    assign amm_readdata = rdata_q;

endmodule

// File: tb/tb_amm_ahb_arbiter.sv
// Bench for amm_ahb_arbiter (4 ports): transaction-level reference checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_amm_ahb_arbiter;
    localparam int N = 4;

    logic            aclk;
    logic            aresetn;
    logic [32*N-1:0] amm_address;
    logic [32*N-1:0] amm_writedata;
    logic [4*N-1:0]  amm_byteenable;
    logic [N-1:0]    amm_write;
    logic [N-1:0]    amm_read;
    logic [N-1:0]    amm_waitrequest;
    logic [31:0]     amm_readdata;
    logic [N-1:0]    amm_readdatavalid;
    logic [N-1:0]    amm_response;
    logic [31:0]     ahb_haddr;
    logic [2:0]      ahb_hsize;
    logic [1:0]      ahb_htrans;
    logic            ahb_hwrite;
    logic [31:0]     ahb_hwdata;
    logic [2:0]      ahb_hburst;
    logic [31:0]     ahb_hrdata;
    logic            ahb_hresp;
    logic            ahb_hready;

    int n_tests = 0;
    int n_fail  = 0;

    amm_ahb_arbiter #(.N_PORTS(N)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .amm_address(amm_address), .amm_writedata(amm_writedata),
        .amm_byteenable(amm_byteenable), .amm_write(amm_write), .amm_read(amm_read),
        .amm_waitrequest(amm_waitrequest), .amm_readdata(amm_readdata),
        .amm_readdatavalid(amm_readdatavalid), .amm_response(amm_response),
        .ahb_haddr(ahb_haddr), .ahb_hsize(ahb_hsize), .ahb_htrans(ahb_htrans),
        .ahb_hwrite(ahb_hwrite), .ahb_hwdata(ahb_hwdata), .ahb_hburst(ahb_hburst),
        .ahb_hrdata(ahb_hrdata), .ahb_hresp(ahb_hresp), .ahb_hready(ahb_hready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transfer is: granted -> waits for one hready (address) -> waits for one
    // hready (data, sample hrdata/hresp) -> one acknowledge cycle.
    bit          m_busy;
    int          m_port;
    int          m_phase;   // 0 address, 1 data, 2 acknowledge
    int          m_last;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_size;
    logic        m_wr, m_resp;

    function automatic void be_dec(input logic [3:0] be, output logic [2:0] sz, output logic [1:0] lsb);
        sz  = 3'd2;
        lsb = 2'd0;
        if ($countones(be) == 1) begin
            sz = 3'd0;
            for (int b = 0; b < 4; b++) if (be[b]) lsb = 2'(b);
        end else if (be == 4'b0011) begin
            sz = 3'd1;
        end else if (be == 4'b1100) begin
            sz = 3'd1;
            lsb = 2'd2;
        end
    endfunction

    initial begin : model
        logic [N-1:0] ew, ev, er, rq;
        logic [1:0]   et;
        logic [2:0]   sz;
        logic [1:0]   lsb;
        int           c;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_busy = 0; m_phase = 0; m_last = N - 1; m_port = 0;
                m_addr = 0; m_wdata = 0; m_rdata = 0; m_size = 3'b010; m_wr = 0; m_resp = 0;
            end
            et = (m_busy && m_phase == 0) ? 2'b10 : 2'b00;
            ew = '1; ev = '0; er = '0;
            if (m_busy && m_phase == 2) begin
                ew[m_port] = 1'b0;
                ev[m_port] = !m_wr;
                er[m_port] = m_resp;
            end
            chk("m_htrans", ahb_htrans, et);
            chk("m_haddr", ahb_haddr, m_addr);
            chk("m_hsize", ahb_hsize, m_size);
            chk("m_hwrite", ahb_hwrite, m_wr);
            chk("m_hwdata", ahb_hwdata, m_wdata);
            chk("m_hburst", ahb_hburst, 3'b000);
            chk("m_waitreq", amm_waitrequest, ew);
            chk("m_rdvalid", amm_readdatavalid, ev);
            chk("m_response", amm_response, er);
            chk("m_readdata", amm_readdata, m_rdata);
            if (aresetn) begin
                if (!m_busy) begin
                    rq = amm_read | amm_write;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (!m_busy && rq[c]) begin
                            m_busy = 1; m_phase = 0; m_port = c;
                            be_dec(amm_byteenable[4*c +: 4], sz, lsb);
                            m_addr  = {amm_address[32*c+2 +: 30], lsb};
                            m_size  = sz;
                            m_wr    = amm_write[c];
                            m_wdata = amm_writedata[32*c +: 32];
                        end
                    end
                end else if (m_phase == 0) begin
                    if (ahb_hready) m_phase = 1;
                end else if (m_phase == 1) begin
                    if (ahb_hready) begin
                        m_resp = ahb_hresp;
                        if (!m_wr) m_rdata = ahb_hrdata;
                        m_phase = 2;
                    end
                end else begin
                    m_last = m_port;
                    m_busy = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic setc(input int p, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        amm_address[32*p +: 32]   = a;
        amm_writedata[32*p +: 32] = d;
        amm_byteenable[4*p +: 4]  = be;
        amm_write[p] = w;
        amm_read[p]  = r;
    endtask

    task automatic clr(input int p);
        amm_write[p] = 1'b0;
        amm_read[p]  = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic wait_ack(input int p, output int lat);
        lat = 0;
        while (amm_waitrequest[p] && lat < 40) begin
            tick();
            lat++;
        end
        chk("acked", amm_waitrequest[p], 1'b0);
    endtask

    task automatic new_cmd(input int p);
        logic [3:0] be;
        int k;
        case ($urandom_range(0, 9))
            0: be = 4'b0001; 1: be = 4'b0010; 2: be = 4'b0100; 3: be = 4'b1000;
            4: be = 4'b0011; 5: be = 4'b1100; 6: be = 4'b0110; 7: be = 4'b0000;
            default: be = 4'b1111;
        endcase
        k = $urandom_range(0, 9);
        setc(p, k < 5, k == 0 || k >= 5, $urandom, $urandom, be);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int lat;
        logic [N-1:0] acked, exp4;
        amm_address = '0; amm_writedata = '0; amm_byteenable = '0;
        amm_write = '0; amm_read = '0;
        ahb_hrdata = '0; ahb_hresp = 1'b0; ahb_hready = 1'b1;
        aresetn = 1'b0;
        repeat (3) tick();
        chk("rst_htrans", ahb_htrans, 2'b00);
        chk("rst_hsize", ahb_hsize, 3'b010);
        chk("rst_haddr", ahb_haddr, 32'h0);
        chk("rst_wait", amm_waitrequest, 4'hF);
        chk("rst_rdv", amm_readdatavalid, 4'h0);
        aresetn = 1'b1;
        tick();

        // word write, port 0, zero wait
        setc(0, 1, 0, 32'h100, 32'hDEADBEEF, 4'hF);
        tick();
        chk("t1_htrans", ahb_htrans, 2'b10);
        chk("t1_haddr", ahb_haddr, 32'h100);
        chk("t1_hsize", ahb_hsize, 3'b010);
        chk("t1_hwrite", ahb_hwrite, 1'b1);
        tick();
        chk("t1_htrans_d", ahb_htrans, 2'b00);
        chk("t1_hwdata", ahb_hwdata, 32'hDEADBEEF);
        chk("t1_wait_c2", amm_waitrequest, 4'hF);
        tick();
        chk("t1_ack", amm_waitrequest, 4'b1110);
        tick();
        clr(0);
        chk("t1_after", amm_waitrequest, 4'hF);

        // byte read, port 1, two data wait states
        setc(1, 0, 1, 32'h2000_0040, 32'h0, 4'b0100);
        tick();
        chk("t2_haddr", ahb_haddr, 32'h2000_0042);
        chk("t2_hsize", ahb_hsize, 3'b000);
        chk("t2_htrans", ahb_htrans, 2'b10);
        tick();
        ahb_hready = 1'b0; ahb_hrdata = 32'hFFFF_FFFF;
        tick();
        tick();
        ahb_hready = 1'b1; ahb_hrdata = 32'h00AB_0000;
        chk("t2_rdv_c4", amm_readdatavalid, 4'h0);
        tick();
        chk("t2_rdv_c5", amm_readdatavalid, 4'b0010);
        chk("t2_rdata", amm_readdata, 32'h00AB_0000);
        chk("t2_wait_c5", amm_waitrequest, 4'b1101);
        tick();
        clr(1); ahb_hrdata = 32'h0;

        // slave error on a port 0 write
        setc(0, 1, 0, 32'h300, 32'h1234_5678, 4'hF);
        tick();
        tick();
        ahb_hready = 1'b0; ahb_hresp = 1'b1;
        tick();
        ahb_hready = 1'b1;
        tick();
        ahb_hresp = 1'b0;
        chk("t3_resp", amm_response, 4'b0001);
        chk("t3_wait", amm_waitrequest, 4'b1110);
        tick();
        clr(0);
        setc(0, 1, 0, 32'h304, 32'h1, 4'hF);
        wait_ack(0, lat);
        chk("t3b_lat", lat, 3);
        chk("t3b_resp", amm_response, 4'h0);
        tick();
        clr(0);

        // read and write together: write wins
        setc(0, 1, 1, 32'h400, 32'hCAFE_F00D, 4'b0011);
        wait_ack(0, lat);
        chk("t6_lat", lat, 3);
        chk("t6_rdv", amm_readdatavalid, 4'h0);
        chk("t6_hwrite", ahb_hwrite, 1'b1);
        chk("t6_hsize", ahb_hsize, 3'b001);
        tick();
        clr(0);

        // all four ports requesting continuously from reset
        do_reset();
        for (int p = 0; p < N; p++) setc(p, 0, 1, 32'h1000 * (p + 1), 32'h0, 4'hF);
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp4 = 4'hF;
            if (c % 4 == 3) exp4[(c / 4) % 4] = 1'b0;
            chk("t4_rotation", amm_waitrequest, exp4);
        end
        for (int p = 0; p < N; p++) clr(p);
        tick();

        // reset during the data phase of a read
        do_reset();
        setc(2, 0, 1, 32'h500, 32'h0, 4'hF);
        tick();
        tick();
        ahb_hready = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("t5_htrans", ahb_htrans, 2'b00);
        chk("t5_wait", amm_waitrequest, 4'hF);
        chk("t5_rdv", amm_readdatavalid, 4'h0);
        ahb_hready = 1'b1;
        tick();
        tick();
        aresetn = 1'b1;
        setc(0, 0, 1, 32'h600, 32'h0, 4'hF);
        tick();
        chk("t5_regrant_htrans", ahb_htrans, 2'b10);
        chk("t5_regrant_haddr", ahb_haddr, 32'h600);
        wait_ack(0, lat);
        tick();
        clr(0);
        wait_ack(2, lat);
        tick();
        clr(2);

        // randomized traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge aclk);
            #1;
            acked = ~amm_waitrequest;
            tick();
            for (int p = 0; p < N; p++) begin
                if (acked[p]) clr(p);
                if (!(amm_read[p] | amm_write[p]) && $urandom_range(0, 99) < 35) new_cmd(p);
            end
            ahb_hready = ($urandom_range(0, 99) < 70);
            ahb_hrdata = $urandom;
            ahb_hresp  = ($urandom_range(0, 99) < 20);
        end
        for (int cyc = 0; cyc < 400 && (amm_read | amm_write) != '0; cyc++) begin
            @(negedge aclk);
            #1;
            acked = ~amm_waitrequest;
            tick();
            for (int p = 0; p < N; p++) if (acked[p]) clr(p);
            ahb_hready = ($urandom_range(0, 99) < 70);
            ahb_hrdata = $urandom;
            ahb_hresp  = ($urandom_range(0, 99) < 20);
        end
        chk("drain", amm_read | amm_write, 4'h0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
